// File: rtl/addsub_pkg.sv
// Shared opcode encodings and flag bit positions for the add/sub/accumulate pipeline.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_COUT = 3;

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational WIDTH-bit ripple-carry adder with carry in/out; zero latency, no flow control.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/pipelined_add_sub_acc.sv
// Two-stage add/sub/accumulate: result 2 cycles after accept, stalls via in_ready when S2 is held.
// Define ADDSUB_SAT_EN to saturate overflowing results (and acc) to signed max/min.
module pipelined_add_sub_acc
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [WIDTH-1:0] acc;

    logic             s1_adv;
    logic             accept;
    logic             xfer;

    logic             is_acc;
    logic             is_sub;
    logic [WIDTH-1:0] x_opnd;
    logic [WIDTH-1:0] y_raw;
    logic [WIDTH-1:0] y_opnd;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] res;
    logic [3:0]       nxt_flags;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s1_adv;
    assign accept   = in_valid && in_ready && !rst;
    assign xfer     = s1_vld && s1_adv;

    assign is_acc = (s1_op == OP_ACC_ADD) || (s1_op == OP_ACC_SUB);
    assign is_sub = (s1_op == OP_SUB) || (s1_op == OP_ACC_SUB);

    // Subtraction is X + ~Y + 1: invert Y here, the +1 enters as carry-in.
    assign x_opnd = is_acc ? acc : s1_a;
    assign y_raw  = is_acc ? s1_a : s1_b;
    assign y_opnd = is_sub ? ~y_raw : y_raw;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (x_opnd),
        .y    (y_opnd),
        .cin  (is_sub),
        .sum  (sum),
        .cout (cout)
    );

    assign ovf = (x_opnd[WIDTH-1] == y_opnd[WIDTH-1]) && (sum[WIDTH-1] != x_opnd[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    // Overflow direction always follows the sign of X.
    assign res = ovf ? (x_opnd[WIDTH-1] ? SMIN : SMAX) : sum;
`else
    assign res = sum;
`endif

    always_comb begin
        nxt_flags            = '0;
        nxt_flags[FLAG_COUT] = cout;
        nxt_flags[FLAG_OVF]  = ovf;
        nxt_flags[FLAG_NEG]  = res[WIDTH-1];
        nxt_flags[FLAG_ZERO] = (res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_ADD;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (accept) begin
                s1_vld <= 1'b1;
                s1_a   <= a;
                s1_b   <= b;
                s1_op  <= op_e'(op);
            end else if (xfer) begin
                s1_vld <= 1'b0;
            end

            if (xfer) begin
                out_valid <= 1'b1;
                result    <= res;
                flags     <= nxt_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Clear wins over a same-cycle ACC transfer, which already used the old acc.
            if (acc_clr) begin
                acc <= '0;
            end else if (xfer && is_acc) begin
                acc <= res;
            end
        end
    end

endmodule
